// File: rtl/dap_pkg.sv
// Shared types and constants for the DAP read-return buffer.
package dap_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b01,
        BUSY   = 2'b10
    } dap_resp_e;

    // Access-port select codes
    localparam logic [7:0] APB  = 8'h00;
    localparam logic [7:0] AHB  = 8'h01;
    localparam logic [7:0] AXI  = 8'h02;
    localparam logic [7:0] JTAG = 8'h03;

    localparam int OVF_CNT_W = 8;

    // Width of an index into n items; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dap_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the
// rr pointer. The pointer moves past the grantee only when adv is high.
module dap_rr_arb
    import dap_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] rr_ptr;

    // First requester at or after rr_ptr, wrapping modulo N
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

    // Pointer advances to grantee+1 on a taken grant; clr returns it to 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (clr) begin
            rr_ptr <= '0;
        end else if (adv && (|req)) begin
            if (int'(gnt_idx) == N - 1) rr_ptr <= '0;
            else                        rr_ptr <= gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/dap_ap_rbuf.sv
// DAP read-return buffer: per-AP one-entry holding slots drained round-robin
// into a shared first-word-fall-through FIFO with source tag, level, flush and
// sticky overflow. Define DAP_RBUF_OVF_CNT_EN to build the saturating
// dropped-push counter; otherwise ovf_cnt reads as zero.
//
// Handshake: a push on channel i is taken when push[i] & push_rdy[i]; a push
// with push_rdy[i] low is dropped and flagged. The read side presents the head
// while rvalid is high; pop consumes it, pop with rvalid low is ignored.
module dap_ap_rbuf
    import dap_pkg::*;
#(
    parameter int NUM_AP = 2,
    parameter int DATA_W = 32,
    parameter int RESP_W = 2,
    parameter int DEPTH  = 64,
    localparam int SRC_W = idx_w(NUM_AP),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [NUM_AP-1:0]        push,
    input  logic [NUM_AP*DATA_W-1:0] wdata,
    input  logic [NUM_AP*RESP_W-1:0] wresp,
    output logic [NUM_AP-1:0]        push_rdy,
    input  logic                     pop,
    output logic                     rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [RESP_W-1:0]        rresp,
    output logic [SRC_W-1:0]         rsrc,
    output logic                     empty,
    output logic                     full,
    output logic [LVL_W-1:0]         level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [OVF_CNT_W-1:0]     ovf_cnt
);

    logic [NUM_AP-1:0] slot_vld;
    logic [DATA_W-1:0] slot_data [NUM_AP];
    logic [RESP_W-1:0] slot_resp [NUM_AP];

    logic [NUM_AP-1:0] gnt;
    logic [NUM_AP-1:0] drain;
    logic [NUM_AP-1:0] drop;
    logic [SRC_W-1:0]  gnt_idx;
    logic              pop_ok;
    logic              do_drain;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [RESP_W-1:0] mem_resp [DEPTH];
    logic [SRC_W-1:0]  mem_src  [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    assign empty  = (level == '0);
    assign full   = (level == LVL_W'(DEPTH));
    assign rvalid = ~empty;
    assign rdata  = empty ? '0 : mem_data[rptr];
    assign rresp  = empty ? '0 : mem_resp[rptr];
    assign rsrc   = empty ? '0 : mem_src[rptr];

    // A full FIFO still accepts a drain when the head is popped the same cycle
    assign pop_ok   = pop & ~empty & ~flush;
    assign do_drain = ~flush & (|slot_vld) & (~full | pop_ok);
    assign drain    = gnt & {NUM_AP{do_drain}};
    assign push_rdy = ~slot_vld | drain;
    assign drop     = push & ~push_rdy & {NUM_AP{~flush}};

    dap_rr_arb #(.N(NUM_AP)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (flush),
        .req     (slot_vld),
        .adv     (do_drain),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Holding slots: capture accepted pushes, empty on drain or flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_vld <= '0;
            for (int i = 0; i < NUM_AP; i++) begin
                slot_data[i] <= '0;
                slot_resp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_AP; i++) begin
                if (flush) begin
                    slot_vld[i] <= 1'b0;
                end else if (push[i] && push_rdy[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_data[i] <= wdata[i*DATA_W +: DATA_W];
                    slot_resp[i] <= wresp[i*RESP_W +: RESP_W];
                end else if (drain[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage, written with the granted slot; contents survive reset
    always_ff @(posedge clk) begin
        if (do_drain) begin
            mem_data[wptr] <= slot_data[gnt_idx];
            mem_resp[wptr] <= slot_resp[gnt_idx];
            mem_src[wptr]  <= gnt_idx;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_drain) wptr <= wptr + PTR_W'(1);
            if (pop_ok)   rptr <= rptr + PTR_W'(1);
            if (do_drain && !pop_ok)      level <= level + LVL_W'(1);
            else if (!do_drain && pop_ok) level <= level - LVL_W'(1);
        end
    end

    // Sticky overflow: a drop in the same cycle outranks ovf_clr
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         ovf <= 1'b0;
        else if (|drop)    ovf <= 1'b1;
        else if (ovf_clr)  ovf <= 1'b0;
    end

`ifdef DAP_RBUF_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_nxt;

    // Add this cycle's drops to the (possibly cleared) count, saturating
    always_comb begin
        int sum;
        sum = ovf_clr ? 0 : int'(ovf_cnt);
        for (int i = 0; i < NUM_AP; i++) sum = sum + int'(drop[i]);
        ovf_cnt_nxt = (sum > 255) ? 8'hFF : OVF_CNT_W'(sum);
    end

    // Dropped-push counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovf_cnt <= '0;
        else       ovf_cnt <= ovf_cnt_nxt;
    end
`else
    assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dap_ap_rbuf.sv
// Directed testbench for dap_ap_rbuf (NUM_AP=2, DEPTH=4).
module tb_dap_ap_rbuf;

    localparam int NUM_AP = 2;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;
    localparam int DEPTH  = 4;

`ifdef DAP_RBUF_OVF_CNT_EN
    localparam logic [7:0] EXP_CNT1 = 8'd1;
`else
    localparam logic [7:0] EXP_CNT1 = 8'd0;
`endif

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     flush;
    logic [NUM_AP-1:0]        push;
    logic [NUM_AP*DATA_W-1:0] wdata;
    logic [NUM_AP*RESP_W-1:0] wresp;
    logic [NUM_AP-1:0]        push_rdy;
    logic                     pop;
    logic                     rvalid;
    logic [DATA_W-1:0]        rdata;
    logic [RESP_W-1:0]        rresp;
    logic [0:0]               rsrc;
    logic                     empty;
    logic                     full;
    logic [2:0]               level;
    logic                     ovf;
    logic                     ovf_clr;
    logic [7:0]               ovf_cnt;

    int checks = 0;
    int errors = 0;

    dap_ap_rbuf #(.NUM_AP(NUM_AP), .DATA_W(DATA_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .push(push), .wdata(wdata), .wresp(wresp),
        .push_rdy(push_rdy), .pop(pop), .rvalid(rvalid), .rdata(rdata), .rresp(rresp),
        .rsrc(rsrc), .empty(empty), .full(full), .level(level), .ovf(ovf),
        .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; push = '0; wdata = '0; wresp = '0; pop = 1'b0; ovf_clr = 1'b0;
        cyc(); cyc();
        checks++; if (push_rdy !== 2'b11) begin errors++; $display("FAIL reset_push_rdy: got %b exp 11", push_rdy); end
        checks++; if ({rvalid, empty, full} !== 3'b010) begin errors++; $display("FAIL reset_flags: got %b exp 010", {rvalid, empty, full}); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
        checks++; if ({rdata, rresp, rsrc} !== 35'd0) begin errors++; $display("FAIL reset_head: got %h exp 0", {rdata, rresp, rsrc}); end
        checks++; if ({ovf, ovf_cnt} !== 9'd0) begin errors++; $display("FAIL reset_ovf: got %h exp 0", {ovf, ovf_cnt}); end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        push = 2'b01; wdata = {32'h0, 32'hDEAD_BEEF}; wresp = '0;
        cyc();
        push = '0;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_n1_rvalid: got %b exp 0", rvalid); end
        cyc();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b exp 1", rvalid); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h exp deadbeef", rdata); end
        checks++; if ({rsrc, rresp} !== 3'd0) begin errors++; $display("FAIL single_src_resp: got %b exp 000", {rsrc, rresp}); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d exp 1", level); end
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        checks++; if (empty !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL single_pop: empty %b rdata %h exp 1 0", empty, rdata); end
    endtask

    task automatic test_arbitration();
        do_flush();
        // rr = 0: both slots fill together, source 0 drains first
        push = 2'b11; wdata = {32'hA1A1_0001, 32'hA0A0_0000}; wresp = 4'b01_00;
        cyc();
        push = '0;
        cyc(); cyc();
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL arb0_level: got %0d exp 2", level); end
        checks++; if (rsrc !== 1'b0 || rdata !== 32'hA0A0_0000) begin errors++; $display("FAIL arb0_first: src %0d data %h exp 0 a0a00000", rsrc, rdata); end
        pop = 1'b1; cyc(); pop = 1'b0;
        checks++; if (rsrc !== 1'b1 || rdata !== 32'hA1A1_0001 || rresp !== 2'b01) begin errors++; $display("FAIL arb0_second: src %0d data %h resp %b exp 1 a1a10001 01", rsrc, rdata, rresp); end
        pop = 1'b1; cyc(); pop = 1'b0;
        // a lone drain of source 0 leaves rr = 1
        push = 2'b01; wdata = {32'h0, 32'h0000_00CC};
        cyc(); push = '0; cyc();
        pop = 1'b1; cyc(); pop = 1'b0;
        push = 2'b11; wdata = {32'hB1B1_0001, 32'hB0B0_0000}; wresp = '0;
        cyc();
        push = '0;
        cyc(); cyc();
        checks++; if (rsrc !== 1'b1 || rdata !== 32'hB1B1_0001) begin errors++; $display("FAIL arb1_first: src %0d data %h exp 1 b1b10001", rsrc, rdata); end
        pop = 1'b1; cyc(); pop = 1'b0;
        checks++; if (rsrc !== 1'b0 || rdata !== 32'hB0B0_0000) begin errors++; $display("FAIL arb1_second: src %0d data %h exp 0 b0b00000", rsrc, rdata); end
        pop = 1'b1; cyc(); pop = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arb1_empty: got %b exp 1", empty); end
    endtask

    // Five back-to-back pushes on channel 0: four reach the FIFO, one is held
    task automatic fill_fifo(input logic [31:0] base);
        for (int k = 0; k < 5; k++) begin
            push = 2'b01; wdata = {32'h0, base + 32'(k)};
            cyc();
        end
        push = '0;
    endtask

    task automatic test_full();
        do_flush();
        fill_fifo(32'h10);
        checks++; if (full !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL full_flag: full %b level %0d exp 1 4", full, level); end
        checks++; if (push_rdy !== 2'b10) begin errors++; $display("FAIL full_push_rdy: got %b exp 10", push_rdy); end
        push = 2'b01; wdata = {32'h0, 32'h99};
        cyc();
        push = '0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b exp 1", ovf); end
        checks++; if (ovf_cnt !== EXP_CNT1) begin errors++; $display("FAIL full_ovf_cnt: got %0d exp %0d", ovf_cnt, EXP_CNT1); end
        pop = 1'b1;
        #1;
        checks++; if (push_rdy[0] !== 1'b1 || rdata !== 32'h10) begin errors++; $display("FAIL full_pop_drain: rdy %b rdata %h exp 1 10", push_rdy[0], rdata); end
        cyc();
        pop = 1'b0;
        checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_pop_level: level %0d full %b exp 4 1", level, full); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (rdata !== 32'h10 + 32'(k)) begin errors++; $display("FAIL full_drain_order: got %h exp %h", rdata, 32'h10 + 32'(k)); end
            pop = 1'b1; cyc(); pop = 1'b0;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_final_empty: got %b exp 1", empty); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin
            push = 2'b01; wdata = {32'h0, 32'h40 + 32'(k)};
            cyc();
        end
        push = '0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre_level: got %0d exp 3", level); end
        flush = 1'b1; push = 2'b10; wdata = {32'h7777_7777, 32'h0};
        cyc();
        flush = 1'b0; push = '0;
        checks++; if (empty !== 1'b1 || level !== 3'd0 || rvalid !== 1'b0) begin errors++; $display("FAIL flush_fifo: empty %b level %0d rvalid %b exp 1 0 0", empty, level, rvalid); end
        checks++; if (push_rdy !== 2'b11) begin errors++; $display("FAIL flush_push_rdy: got %b exp 11", push_rdy); end
        checks++; if (ovf !== 1'b1 || ovf_cnt !== EXP_CNT1) begin errors++; $display("FAIL flush_ovf_kept: ovf %b cnt %0d exp 1 %0d", ovf, ovf_cnt, EXP_CNT1); end
        cyc();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_push_discarded: empty %b exp 1", empty); end
        // clear together with a fresh drop: the drop wins
        fill_fifo(32'h50);
        push = 2'b01; wdata = {32'h0, 32'hEE}; ovf_clr = 1'b1;
        cyc();
        push = '0; ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b1 || ovf_cnt !== EXP_CNT1) begin errors++; $display("FAIL clr_vs_drop: ovf %b cnt %0d exp 1 %0d", ovf, ovf_cnt, EXP_CNT1); end
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clr: ovf %b cnt %0d exp 0 0", ovf, ovf_cnt); end
        do_flush();
    endtask

    task automatic test_wrap();
        int exp_val = 0;
        int max_lvl = 0;
        for (int c = 0; c < 16; c++) begin
            push  = (c < 10) ? 2'b01 : 2'b00;
            wdata = {32'h0, 32'(c)};
            pop   = rvalid;
            if (rvalid) begin
                checks++; if (rdata !== 32'(exp_val)) begin errors++; $display("FAIL wrap_data: got %0d exp %0d", rdata, exp_val); end
                exp_val++;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
            cyc();
        end
        push = '0; pop = 1'b0;
        checks++; if (exp_val != 10) begin errors++; $display("FAIL wrap_count: got %0d exp 10", exp_val); end
        checks++; if (max_lvl > 2) begin errors++; $display("FAIL wrap_max_level: got %0d exp <=2", max_lvl); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            push = 2'b11; wdata = {32'h6000_0000 + 32'(k), 32'h5000_0000 + 32'(k)};
            cyc();
        end
        push = '0;
        rstn = 1'b0;
        #1;
        checks++; if ({rvalid, empty, full, level} !== {3'b010, 3'd0}) begin errors++; $display("FAIL midrst_flags: got %b exp 010000", {rvalid, empty, full, level}); end
        checks++; if ({rdata, rresp, rsrc} !== 35'd0 || push_rdy !== 2'b11) begin errors++; $display("FAIL midrst_head: head %h rdy %b exp 0 11", {rdata, rresp, rsrc}, push_rdy); end
        cyc();
        rstn = 1'b1;
        cyc();
        push = 2'b10; wdata = {32'hCAFE_F00D, 32'h0}; wresp = 4'b10_00;
        cyc();
        push = '0;
        cyc();
        checks++; if (rdata !== 32'hCAFE_F00D || rsrc !== 1'b1 || rresp !== 2'b10 || level !== 3'd1) begin errors++; $display("FAIL midrst_after: data %h src %0d resp %b level %0d exp cafef00d 1 10 1", rdata, rsrc, rresp, level); end
        pop = 1'b1; cyc(); pop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_full();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
